// File: rtl/axi4s_pkg.sv
// Shared types and constants for the AXI4-Stream slave FIFO front end.
package axi4s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } axi4s_state_e;

    localparam int unsigned DATA_WIDTH_DEF = 48;
    // tlast sits directly above tdata in each FIFO entry
    localparam int unsigned LAST_BIT       = DATA_WIDTH_DEF;

endpackage

// File: rtl/axi4s_sync_fifo.sv
// Register-array synchronous FIFO with occupancy count; DEPTH must be a power of two.
module axi4s_sync_fifo #(
    parameter int unsigned WIDTH = 49,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is not reset; the read side gates it with empty_c
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data_c = mem[rd_ptr];
    assign full_c    = (level == LVL_W'(DEPTH));
    assign empty_c   = (level == '0);

endmodule

// File: rtl/axi4s_slave_fifo_if.sv
// AXI4-Stream slave front end: enable FSM, buffered ready/valid path and tlast frame counter.
module axi4s_slave_fifo_if
    import axi4s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                       axi4s_sclk_i,
    input  logic                       axi4s_rstn_i,
    input  logic                       axi4s_en_i,
    input  logic                       axi4s_svalid_i,
    output logic                       axi4s_sready_o,
    input  logic [DATA_WIDTH-1:0]      axi4s_sdata_i,
    input  logic                       axi4s_slast_i,
    output logic                       axi4s_mvalid_o,
    input  logic                       axi4s_mready_i,
    output logic [DATA_WIDTH-1:0]      axi4s_mdata_o,
    output logic                       axi4s_mlast_o,
    output logic [$clog2(DEPTH+1)-1:0] axi4s_level_o,
    output logic [CNT_WIDTH-1:0]       axi4s_frames_o
);

    localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

    axi4s_state_e         state_q;
    axi4s_state_e         state_d;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [ENTRY_W-1:0]   head;
    logic [CNT_WIDTH-1:0] frames_q;

    always_ff @(posedge axi4s_sclk_i or negedge axi4s_rstn_i) begin
        if (!axi4s_rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RUN follows the enable level sampled at each edge, so reset always leaves one IDLE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (axi4s_en_i)  state_d = RUN;
            RUN:     if (!axi4s_en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign axi4s_sready_o = (state_q == RUN) && axi4s_en_i && !full;
    assign push           = axi4s_svalid_i && axi4s_sready_o;
    assign axi4s_mvalid_o = !empty;
    assign pop            = axi4s_mvalid_o && axi4s_mready_i;

    axi4s_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (axi4s_sclk_i),
        .rst_n     (axi4s_rstn_i),
        .push      (push),
        .pop       (pop),
        .wr_data   ({axi4s_slast_i, axi4s_sdata_i}),
        .rd_data_c (head),
        .full_c    (full),
        .empty_c   (empty),
        .level     (axi4s_level_o)
    );

    assign axi4s_mdata_o = empty ? '0 : head[DATA_WIDTH-1:0];
    assign axi4s_mlast_o = !empty && head[DATA_WIDTH];

    // Frame counter wraps naturally at 2^CNT_WIDTH
    always_ff @(posedge axi4s_sclk_i or negedge axi4s_rstn_i) begin
        if (!axi4s_rstn_i) begin
            frames_q <= '0;
        end else if (pop && head[DATA_WIDTH]) begin
            frames_q <= frames_q + CNT_WIDTH'(1);
        end
    end

    assign axi4s_frames_o = frames_q;

endmodule

// File: tb/tb_axi4s_slave_fifo_if.sv
// Directed + randomized bench for axi4s_slave_fifo_if against a queue-based reference model.
module tb_axi4s_slave_fifo_if;

    localparam int unsigned DW    = 48;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          svalid;
    logic          sready;
    logic [DW-1:0] sdata;
    logic          slast;
    logic          mvalid;
    logic          mready;
    logic [DW-1:0] mdata;
    logic          mlast;
    logic [2:0]    level;
    logic [CW-1:0] frames;

    always #5 clk = ~clk;

    axi4s_slave_fifo_if #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .axi4s_sclk_i   (clk),
        .axi4s_rstn_i   (rstn),
        .axi4s_en_i     (en),
        .axi4s_svalid_i (svalid),
        .axi4s_sready_o (sready),
        .axi4s_sdata_i  (sdata),
        .axi4s_slast_i  (slast),
        .axi4s_mvalid_o (mvalid),
        .axi4s_mready_i (mready),
        .axi4s_mdata_o  (mdata),
        .axi4s_mlast_o  (mlast),
        .axi4s_level_o  (level),
        .axi4s_frames_o (frames)
    );

    // Reference model: buffered beats, enable seen at last edge, frame count
    logic [DW:0]   q[$];
    logic [DW:0]   got[$];
    logic [DW:0]   log_q[$];
    bit            run;
    logic [CW-1:0] exp_frames;
    int            tests;
    int            fails;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return run && en && (q.size() != DEPTH);
    endfunction

    // Called at a falling edge with inputs set; checks outputs, crosses one rising edge, returns at next falling edge
    task automatic step();
        logic [DW:0] head;
        bit          exp_mvalid;
        bit          do_push;
        bit          do_pop;
        #1;
        exp_mvalid = (q.size() != 0);
        head       = exp_mvalid ? q[0] : '0;
        check("sready", 64'(sready), 64'(model_ready()));
        check("mvalid", 64'(mvalid), 64'(exp_mvalid));
        check("mdata",  64'(mdata),  64'(head[DW-1:0]));
        check("mlast",  64'(mlast),  64'(head[DW]));
        check("level",  64'(level),  64'(q.size()));
        check("frames", 64'(frames), 64'(exp_frames));
        do_push = svalid && model_ready();
        do_pop  = exp_mvalid && mready;
        @(posedge clk);
        if (do_pop) begin
            got.push_back(q.pop_front());
            if (got[$][DW]) exp_frames++;
        end
        if (do_push) q.push_back({slast, sdata});
        run = en;
        @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        svalid = 1'b1;
        sdata  = d;
        slast  = l;
        while (!acc && n < 16) begin
            acc = model_ready();
            step();
            n++;
        end
        check("send_accepted", 64'(acc), 64'(1));
        if (acc) log_q.push_back({l, d});
        svalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        svalid = 1'b0;
        mready = 1'b1;
        while (q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("drain_done", 64'(q.size()), 64'(0));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        svalid = 1'b0;
        #1;
        check("rst_sready", 64'(sready), 64'(0));
        check("rst_mvalid", 64'(mvalid), 64'(0));
        check("rst_level",  64'(level),  64'(0));
        check("rst_frames", 64'(frames), 64'(0));
        check("rst_mdata",  64'(mdata),  64'(0));
        @(negedge clk);
        rstn = 1'b1;
        q.delete();
        run = 1'b0;
        exp_frames = '0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  pushed;
        int  n;
        bit  acc;
        tests = 0;
        fails = 0;
        run = 1'b0;
        exp_frames = '0;
        rstn = 1'b0;
        en = 1'b1;
        svalid = 1'b1;
        sdata = 48'h1;
        slast = 1'b0;
        mready = 1'b0;

        // T1: reset with en and svalid held high; first accept on the 2nd edge
        repeat (2) @(negedge clk);
        #1;
        check("t1_rst_sready", 64'(sready), 64'(0));
        check("t1_rst_mvalid", 64'(mvalid), 64'(0));
        check("t1_rst_frames", 64'(frames), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        step();
        step();
        svalid = 1'b0;
        check("t1_first_level", 64'(level), 64'(1));
        check("t1_first_data",  64'(mdata), 64'(1));
        drain();

        // T2: fill with mready low, beat 5 held off, then drain in order
        got.delete();
        mready = 1'b0;
        for (int i = 1; i <= 4; i++) send(48'(i), 1'b0);
        svalid = 1'b1;
        sdata  = 48'h5;
        slast  = 1'b0;
        step();
        step();
        check("t2_full_level",  64'(level),  64'(4));
        check("t2_full_sready", 64'(sready), 64'(0));
        mready = 1'b1;
        send(48'h5, 1'b0);
        drain();
        check("t2_count", 64'(got.size()), 64'(5));
        for (int i = 0; i < got.size(); i++) check("t2_order", 64'(got[i][DW-1:0]), 64'(i + 1));

        // T3: pop at full, refill next cycle, then random backpressure scoreboard
        got.delete();
        log_q.delete();
        mready = 1'b0;
        for (int i = 0; i < 4; i++) send({16'($urandom), 32'($urandom)}, 1'b0);
        svalid = 1'b1;
        sdata  = 48'hC0FFEE;
        slast  = 1'b0;
        mready = 1'b1;
        step();
        check("t3_after_pop_level", 64'(level), 64'(3));
        mready = 1'b0;
        acc = model_ready();
        step();
        if (acc) log_q.push_back({1'b0, 48'hC0FFEE});
        check("t3_refill_level", 64'(level), 64'(4));
        svalid = 1'b0;
        pushed = 0;
        n = 0;
        while (pushed < 100 && n < 3000) begin
            if (!svalid) begin
                svalid = 1'($urandom_range(0, 1));
                sdata  = {16'($urandom), 32'($urandom)};
                slast  = 1'($urandom_range(0, 1));
            end
            mready = 1'($urandom_range(0, 1));
            acc = svalid && model_ready();
            step();
            if (acc) begin
                log_q.push_back({slast, sdata});
                pushed++;
                svalid = 1'b0;
            end
            n++;
        end
        check("t3_random_pushed", 64'(pushed), 64'(100));
        drain();
        check("t3_count", 64'(got.size()), 64'(log_q.size()));
        for (int i = 0; i < got.size() && i < log_q.size(); i++) check("t3_scoreboard", 64'(got[i]), 64'(log_q[i]));

        // T4: five 3-beat frames, then wrap the frame counter
        do_reset();
        got.delete();
        mready = 1'b1;
        for (int f = 0; f < 5; f++)
            for (int b = 0; b < 3; b++) send({16'($urandom), 32'($urandom)}, b == 2);
        drain();
        check("t4_frames", 64'(frames), 64'(5));
        for (int i = 0; i < got.size(); i++) check("t4_mlast_every_3rd", 64'(got[i][DW]), 64'(i % 3 == 2));
        for (int k = 0; k < 65530; k++) send(48'(k), 1'b1);
        drain();
        check("t4_frames_ffff", 64'(frames), 64'(16'hFFFF));
        send(48'h77, 1'b1);
        drain();
        check("t4_frames_wrap", 64'(frames), 64'(0));

        // T5: drop enable with two beats buffered; they drain, then resume after one IDLE cycle
        got.delete();
        mready = 1'b0;
        send(48'hA1, 1'b1);
        send(48'hA2, 1'b1);
        en = 1'b0;
        svalid = 1'b1;
        sdata  = 48'hA3;
        slast  = 1'b1;
        step();
        check("t5_sready_off", 64'(sready), 64'(0));
        mready = 1'b1;
        repeat (3) step();
        check("t5_drained", 64'(got.size()), 64'(2));
        check("t5_level", 64'(level), 64'(0));
        en = 1'b1;
        #1;
        check("t5_idle_cycle", 64'(sready), 64'(0));
        step();
        step();
        send(48'hA4, 1'b1);
        drain();
        check("t5_count", 64'(got.size()), 64'(4));
        for (int i = 0; i < got.size(); i++) check("t5_order", 64'(got[i][DW-1:0]), 64'(48'hA1 + i));

        // T6: asynchronous reset with three beats buffered
        mready = 1'b0;
        for (int i = 0; i < 3; i++) send(48'(i + 16), 1'b0);
        check("t6_pre_level",  64'(level),  64'(3));
        check("t6_pre_mvalid", 64'(mvalid), 64'(1));
        check("t6_pre_frames", 64'(frames), 64'(4));
        #2;
        rstn = 1'b0;
        #1;
        check("t6_mvalid", 64'(mvalid), 64'(0));
        check("t6_level",  64'(level),  64'(0));
        check("t6_frames", 64'(frames), 64'(0));
        check("t6_sready", 64'(sready), 64'(0));
        check("t6_mdata",  64'(mdata),  64'(0));
        @(negedge clk);
        rstn = 1'b1;
        q.delete();
        run = 1'b0;
        exp_frames = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
